module_bcd_adder: RTL and testbench
===================================

MODULE_BCD_ADDER -- requirements
Module: module_bcd_adder

Interface
REQ-001 The block SHALL have the port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port: rst  input  1  asynchronous active-low reset (0 = reset, taking effect immediately, independent of clk).
REQ-003 The block SHALL have the port: start  input  1  request to add the current operands; sampled on the rising edge of clk.
REQ-004 The block SHALL have the port: first_num  input  12  operand A, three packed BCD digits [11:8]=hundreds, [7:4]=tens, [3:0]=units.
REQ-005 The block SHALL have the port: second_num  input  12  operand B, same packing as first_num.
REQ-006 The block SHALL have the port: sum_bcd  output  16  result, four packed BCD digits [15:12]=thousands, then hundreds, tens, units.
REQ-007 The block SHALL have the port: busy  output  1  high while an addition is in progress or its done cycle is active.
REQ-008 The block SHALL have the port: done  output  1  one-cycle pulse that marks sum_bcd/error as freshly valid.
REQ-009 The block SHALL have the port: error  output  1  high when the last accepted operands held a nibble greater than 9.
REQ-010 All outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Function
REQ-011 The control FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-012 In IDLE, edge E0 with start=1 SHALL:
- latch first_num and second_num into internal registers;
- clear the carry, digit index and error;
- move the FSM to ADD.
REQ-013 In ADD, the block SHALL process one digit per edge (units, tens, hundreds on edges E1, E2, E3), using only the latched operands.
REQ-014 Each digit step SHALL compute s = a + b + carry_in as a 5-bit value, then:
- if s > 9, write digit = s + 6 (low 4 bits) and set carry_out = 1;
- otherwise write digit = s and set carry_out = 0.
REQ-015 At E3, the block SHALL write the final carry_out into sum_bcd[15:12] as 0000 or 0001, and move the FSM to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly one cycle, and the next edge SHALL return the FSM to IDLE with done = 0.
REQ-017 The latency SHALL be four cycles: done is high in the cycle after E3, i.e. E0 + 4 cycles in total.
REQ-018 busy SHALL be 1 from E0 until the FSM re-enters IDLE.
REQ-019 start SHALL be ignored while busy = 1, with no restart, no re-latch and no queuing.
REQ-020 Operands SHALL be allowed to change freely after E0 without affecting the result in progress.
REQ-021 If any latched nibble of either operand is greater than 9, the block SHALL at E3:
- set error = 1;
- force sum_bcd = 0x0000;
- keep the normal timing (done still pulses).
REQ-022 sum_bcd and error SHALL hold their values from E3 until the next accepted start.
REQ-023 On the next accepted start, error SHALL clear at E0, and sum_bcd SHALL be overwritten digit by digit during ADD.
REQ-024 During ADD, sum_bcd SHALL be allowed to show partially updated digits; consumers SHALL use sum_bcd only when done = 1 or busy = 0.
REQ-025 A start held high continuously SHALL trigger a new addition on the first IDLE edge after DONE, which is every 5 cycles.

Reset
REQ-026 While rst = 0, the block SHALL force the following, asynchronously:
- the FSM to IDLE;
- sum_bcd = 0x0000, busy = 0, done = 0, error = 0;
- the internal operands, carry and digit index to 0.
REQ-027 A reset asserted mid-ADD or in DONE SHALL abort the operation, with no done pulse and no partial result retained.
REQ-028 After rst returns to 1, the first rising edge SHALL already accept start.

Verification
REQ-029 The bench SHALL cover: first_num=0x123, second_num=0x456, start for 1 cycle -> done pulses at E0+4, sum_bcd=0x0579, error=0.
REQ-030 The bench SHALL cover: 0x999 + 0x999 -> sum_bcd=0x1998 (carry propagates through all digits), error=0.
REQ-031 The bench SHALL cover: 0x0A3 + 0x001 -> error=1, sum_bcd=0x0000, done still pulses at E0+4.
REQ-032 The bench SHALL cover: start pulsed again at E0+2 with new operands 0x111/0x111 -> ignored; result is from the first operands; busy stays high through E0+4.
REQ-033 The bench SHALL cover: rst=0 asserted at E0+2 -> all outputs 0 immediately; no done pulse; a new start after release gives the correct sum.
REQ-034 The bench SHALL cover: 0x000 + 0x000 -> sum_bcd=0x0000, error=0, done pulses once, busy low from E0+5.

Source files
------------

// File: rtl/module_bcd_adder.sv
// Three-digit packed-BCD adder producing a four-digit BCD sum.
// One digit is resolved per clock (units, tens, hundreds), then the final carry
// becomes the thousands digit. All outputs are driven straight from registers.
module module_bcd_adder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [11:0] first_num,
   input  logic [11:0] second_num,
   output logic [15:0] sum_bcd,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [1:0] {
      StIdle,
      StAdd,
      StDone
   } state_e;

   state_e      state_q;
   logic [11:0] a_q;
   logic [11:0] b_q;
   logic        carry_q;
   logic [1:0]  idx_q;
   logic [15:0] sum_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   logic [3:0]  dig_a;
   logic [3:0]  dig_b;
   logic [4:0]  dig_sum;
   logic [4:0]  dig_adj;
   logic [3:0]  dig_out;
   logic        carry_out;
   logic        bad_nibble;

   // One BCD digit step on the digit selected by idx_q, plus operand validity check.
   always_comb begin
      dig_a = 4'd0;
      dig_b = 4'd0;
      unique case (idx_q)
         2'd0: begin
            dig_a = a_q[3:0];
            dig_b = b_q[3:0];
         end
         2'd1: begin
            dig_a = a_q[7:4];
            dig_b = b_q[7:4];
         end
         default: begin
            dig_a = a_q[11:8];
            dig_b = b_q[11:8];
         end
      endcase

      dig_sum = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_q};
      dig_adj = dig_sum + 5'd6;
      if (dig_sum > 5'd9) begin
         dig_out   = dig_adj[3:0];
         carry_out = 1'b1;
      end else begin
         dig_out   = dig_sum[3:0];
         carry_out = 1'b0;
      end

      bad_nibble = (a_q[3:0] > 4'd9) || (a_q[7:4] > 4'd9) || (a_q[11:8] > 4'd9) ||
                   (b_q[3:0] > 4'd9) || (b_q[7:4] > 4'd9) || (b_q[11:8] > 4'd9);
   end

   // Control FSM and all datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         a_q     <= 12'd0;
         b_q     <= 12'd0;
         carry_q <= 1'b0;
         idx_q   <= 2'd0;
         sum_q   <= 16'd0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= first_num;
                  b_q     <= second_num;
                  carry_q <= 1'b0;
                  idx_q   <= 2'd0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= StAdd;
               end
            end
            StAdd: begin
               carry_q <= carry_out;
               idx_q   <= idx_q + 2'd1;
               unique case (idx_q)
                  2'd0: sum_q[3:0] <= dig_out;
                  2'd1: sum_q[7:4] <= dig_out;
                  default: begin
                     // Last digit: commit thousands, or squash the whole sum on bad input.
                     if (bad_nibble) begin
                        sum_q <= 16'd0;
                        err_q <= 1'b1;
                     end else begin
                        sum_q[11:8]  <= dig_out;
                        sum_q[15:12] <= {3'd0, carry_out};
                     end
                     idx_q   <= 2'd0;
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end
               endcase
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign sum_bcd = sum_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign error   = err_q;

endmodule

// File: tb/tb_module_bcd_adder.sv
// Directed bench for module_bcd_adder. Edge E0 accepts start; done is sampled high
// just after E3 (the fourth cycle of the operation) and busy is low just after E4.
module tb_module_bcd_adder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] first_num;
   logic [11:0] second_num;
   logic [15:0] sum_bcd;
   logic        busy;
   logic        done;
   logic        error;

   int errors = 0;
   int checks = 0;

   module_bcd_adder dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .first_num  (first_num),
      .second_num (second_num),
      .sum_bcd    (sum_bcd),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Single-cycle start, then check the full timeline E0..E4.
   task automatic run_add(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [15:0] exp_sum, input logic exp_err);
      first_num  = a;
      second_num = b;
      start      = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      chk1({tag, " busy@E0"}, busy, 1'b1);
      chk1({tag, " done@E0"}, done, 1'b0);
      chk1({tag, " error@E0"}, error, 1'b0);
      first_num  = 12'hFFF;                     // operands may change freely after E0
      second_num = 12'hFFF;
      tick();                                   // E1
      chk1({tag, " done@E1"}, done, 1'b0);
      tick();                                   // E2
      chk1({tag, " done@E2"}, done, 1'b0);
      chk1({tag, " busy@E2"}, busy, 1'b1);
      tick();                                   // E3
      chk1({tag, " done@E3"}, done, 1'b1);
      chk1({tag, " busy@E3"}, busy, 1'b1);
      chk16({tag, " sum@E3"}, sum_bcd, exp_sum);
      chk1({tag, " error@E3"}, error, exp_err);
      tick();                                   // E4
      chk1({tag, " done@E4"}, done, 1'b0);
      chk1({tag, " busy@E4"}, busy, 1'b0);
      chk16({tag, " sum held"}, sum_bcd, exp_sum);
      chk1({tag, " error held"}, error, exp_err);
   endtask

   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      first_num  = 12'd0;
      second_num = 12'd0;
      #12;
      chk16("reset sum", sum_bcd, 16'h0000);
      chk1("reset busy", busy, 1'b0);
      chk1("reset done", done, 1'b0);
      chk1("reset error", error, 1'b0);

      // First edge after release must accept start.
      rst = 1'b1;
      run_add("123+456", 12'h123, 12'h456, 16'h0579, 1'b0);
      run_add("999+999", 12'h999, 12'h999, 16'h1998, 1'b0);
      run_add("0A3+001", 12'h0A3, 12'h001, 16'h0000, 1'b1);

      // Start re-pulsed at E2 with new operands must be ignored.
      first_num  = 12'h250;
      second_num = 12'h375;
      start      = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      chk1("ign error cleared@E0", error, 1'b0);
      tick();                                   // E1
      first_num  = 12'h111;
      second_num = 12'h111;
      start      = 1'b1;
      tick();                                   // E2 samples start=1 while busy
      start = 1'b0;
      chk1("ign busy@E2", busy, 1'b1);
      tick();                                   // E3
      chk1("ign done@E3", done, 1'b1);
      chk16("ign sum", sum_bcd, 16'h0625);
      tick();                                   // E4
      chk1("ign busy@E4", busy, 1'b0);
      tick();                                   // E5: nothing queued
      chk1("ign no restart", busy, 1'b0);
      chk16("ign sum held", sum_bcd, 16'h0625);

      // Reset asserted mid-ADD clears everything immediately, with no done pulse.
      first_num  = 12'h321;
      second_num = 12'h123;
      start      = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      tick();                                   // E1
      tick();                                   // E2
      #2;
      rst = 1'b0;
      #1;
      chk16("rst sum async", sum_bcd, 16'h0000);
      chk1("rst busy async", busy, 1'b0);
      chk1("rst done async", done, 1'b0);
      chk1("rst error async", error, 1'b0);
      tick();
      chk1("rst no done 1", done, 1'b0);
      tick();
      chk1("rst no done 2", done, 1'b0);
      chk16("rst sum stays 0", sum_bcd, 16'h0000);
      rst = 1'b1;
      run_add("045+055 post-rst", 12'h045, 12'h055, 16'h0100, 1'b0);

      // Zero operands; done pulses once and busy stays low afterwards.
      run_add("000+000", 12'h000, 12'h000, 16'h0000, 1'b0);
      tick();                                   // E5
      chk1("zero done once", done, 1'b0);
      chk1("zero busy low@E5", busy, 1'b0);

      // Start held high: a new addition every five cycles.
      first_num  = 12'h500;
      second_num = 12'h500;
      start      = 1'b1;
      tick();                                   // E0
      tick();                                   // E1
      tick();                                   // E2
      tick();                                   // E3
      chk1("held done 1", done, 1'b1);
      chk16("held sum 1", sum_bcd, 16'h1000);
      tick();                                   // E4
      chk1("held busy@E4", busy, 1'b0);
      tick();                                   // E5 re-accepts
      chk1("held busy@E5", busy, 1'b1);
      start = 1'b0;
      tick();                                   // E6
      tick();                                   // E7
      chk1("held no done@E7", done, 1'b0);
      tick();                                   // E8
      chk1("held done 2", done, 1'b1);
      chk16("held sum 2", sum_bcd, 16'h1000);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
